// File: rtl/seq_pkg.sv
// Shared types and defaults for the serial bit feeder in front of the 101 detector.
package seq_pkg;

  localparam int unsigned SEQ_WORD_W   = 8;
  localparam logic        SEQ_IDLE_BIT = 1'b0;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

endpackage

// File: rtl/seq_hold_reg.sv
// One-entry word buffer with a full flag.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   i_wr_en     - capture i_wr_data and set full
//   i_wr_data   - word to store
//   i_take      - release the stored word (clears full)
//   o_data      - stored word
//   o_full      - a word is stored
// The caller never asserts i_wr_en and i_take together.
module seq_hold_reg
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH = SEQ_WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_take,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full
);

  logic [WIDTH-1:0] r_data;
  logic             r_full;

  // Storage and occupancy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else if (i_wr_en) begin
      r_data <= i_wr_data;
      r_full <= 1'b1;
    end else if (i_take) begin
      r_full <= 1'b0;
    end
  end

  assign o_data = r_data;
  assign o_full = r_full;

endmodule

// File: rtl/seq_serializer.sv
// Parallel-to-serial feeder: accepts WIDTH-bit words on a valid/ready
// handshake and emits one bit per clock on x, with a one-word hold register
// so consecutive words stream without gaps.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   din        - parallel word
//   din_valid  - din holds a word
//   din_ready  - a word can be accepted this cycle (combinational)
//   x          - serial bit (IDLE_BIT when x_valid is low)
//   x_valid    - x carries a data bit
//   sof, eof   - x is the first / last bit of a word
//   busy       - a word is shifting or held
module seq_serializer
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH     = SEQ_WORD_W,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        IDLE_BIT  = SEQ_IDLE_BIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             sof,
  output logic             eof,
  output logic             busy
);

  localparam int unsigned     CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  ser_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt, w_shift_adv;
  logic             r_x, r_x_valid, r_sof, r_eof;
  logic             w_x_nxt, w_x_valid_nxt, w_sof_nxt, w_eof_nxt;
  logic             w_accept, w_last;
  logic             w_hold_wr, w_hold_take, w_hold_full;
  logic [WIDTH-1:0] w_hold_data;

  seq_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_hold_wr),
    .i_wr_data (din),
    .i_take    (w_hold_take),
    .o_data    (w_hold_data),
    .o_full    (w_hold_full)
  );

  assign din_ready = !w_hold_full && !rst;
  assign w_accept  = din_valid && din_ready;
  assign w_last    = (r_cnt == CNT_LAST);

  // Shifter advanced by one bit towards the output end.
  always_comb begin
    if (MSB_FIRST) w_shift_adv = {r_shift[WIDTH-2:0], 1'b0};
    else           w_shift_adv = {1'b0, r_shift[WIDTH-1:1]};
  end

  // Next state, counter, shifter and hold control; outputs are precomputed
  // from the next state so they register in step with it.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_hold_wr   = 1'b0;
    w_hold_take = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = SHIFT;
          w_cnt_nxt   = '0;
          w_shift_nxt = din;
        end
      end
      SHIFT: begin
        if (!w_last) begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          w_shift_nxt = w_shift_adv;
          w_hold_wr   = w_accept;
        end else if (w_hold_full) begin
          // din_ready is low here, so no write can collide with the take.
          w_hold_take = 1'b1;
          w_cnt_nxt   = '0;
          w_shift_nxt = w_hold_data;
        end else if (w_accept) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = din;
        end else begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    w_x_valid_nxt = (w_state_nxt == SHIFT);
    w_x_nxt       = IDLE_BIT;
    if (w_x_valid_nxt) begin
      w_x_nxt = MSB_FIRST ? w_shift_nxt[WIDTH-1] : w_shift_nxt[0];
    end
    w_sof_nxt = w_x_valid_nxt && (w_cnt_nxt == '0);
    w_eof_nxt = w_x_valid_nxt && (w_cnt_nxt == CNT_LAST);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_x       <= IDLE_BIT;
      r_x_valid <= 1'b0;
      r_sof     <= 1'b0;
      r_eof     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_x       <= w_x_nxt;
      r_x_valid <= w_x_valid_nxt;
      r_sof     <= w_sof_nxt;
      r_eof     <= w_eof_nxt;
    end
  end

  assign x       = r_x;
  assign x_valid = r_x_valid;
  assign sof     = r_sof;
  assign eof     = r_eof;
  assign busy    = (r_state == SHIFT) || w_hold_full;

endmodule
